universal_shift_serializer: RTL and testbench

- WIDTH-bit register built on the team's D flip-flop style; sits directly downstream of the single-bit D FF / latch stage and consumes it as a storage bank.
- Manual modes: hold, shift right, shift left, parallel load.
- Auto-serialize mode: START loads a word and shifts it out LSB-first on SO_LSB over WIDTH cycles, then pulses DONE.

---
 rtl/universal_shift_serializer.sv | 101 ++++++++++
 tb/tb_universal_shift_serializer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/universal_shift_serializer.sv
// Universal shift register with manual hold/shift/load modes and an automatic
// LSB-first serializer that pulses DONE once the whole word has been shifted out.
module universal_shift_serializer #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             START,
  input  logic [WIDTH-1:0] D,
  input  logic             SI_MSB,
  input  logic             SI_LSB,
  output logic [WIDTH-1:0] Q,
  output logic             SO_LSB,
  output logic             SO_MSB,
  output logic             BUSY,
  output logic             DONE,
  output logic [CW-1:0]    CNT
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [CW-1:0] LastIdx = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StIdle;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        // START outranks any manual operation requested in the same cycle.
        if (START) begin
          q_d     = D;
          cnt_d   = '0;
          state_d = StShift;
        end else if (EN) begin
          unique case (MODE)
            2'b00: q_d = q_q;
            2'b01: q_d = {SI_MSB, q_q[WIDTH-1:1]};
            2'b10: q_d = {q_q[WIDTH-2:0], SI_LSB};
            2'b11: q_d = D;
          endcase
        end
      end
      StShift: begin
        q_d = {SI_MSB, q_q[WIDTH-1:1]};
        if (cnt_q == LastIdx) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Status flags come straight from flops so they cannot glitch.
  always_comb begin
    busy_d = (state_d == StShift);
    done_d = (state_d == StDone);
  end

  assign Q      = q_q;
  assign SO_LSB = q_q[0];
  assign SO_MSB = q_q[WIDTH-1];
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign CNT    = cnt_q;

endmodule

// File: tb/tb_universal_shift_serializer.sv
// Directed self-checking bench for universal_shift_serializer (WIDTH = 8).
module tb_universal_shift_serializer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = $clog2(WIDTH);

  logic             CLK = 1'b0;
  logic             RST;
  logic             EN;
  logic [1:0]       MODE;
  logic             START;
  logic [WIDTH-1:0] D;
  logic             SI_MSB;
  logic             SI_LSB;
  logic [WIDTH-1:0] Q;
  logic             SO_LSB;
  logic             SO_MSB;
  logic             BUSY;
  logic             DONE;
  logic [CW-1:0]    CNT;

  int tests = 0;
  int fails = 0;

  universal_shift_serializer #(.WIDTH(WIDTH)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (EN),
    .MODE   (MODE),
    .START  (START),
    .D      (D),
    .SI_MSB (SI_MSB),
    .SI_LSB (SI_LSB),
    .Q      (Q),
    .SO_LSB (SO_LSB),
    .SO_MSB (SO_MSB),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .CNT    (CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic busy_e, input logic done_e,
                            input logic [CW-1:0] cnt_e);
    chk({tag, "_busy"}, 32'(BUSY), 32'(busy_e));
    chk({tag, "_done"}, 32'(DONE), 32'(done_e));
    chk({tag, "_cnt"}, 32'(CNT), 32'(cnt_e));
  endtask

  // Checks the eight SHIFT cycles that follow a START edge, ending on the DONE_ST cycle.
  task automatic chk_serial(input string tag, input logic [WIDTH-1:0] word);
    for (int i = 0; i < int'(WIDTH); i++) begin
      chk({tag, "_so"}, 32'(SO_LSB), 32'(word[i]));
      chk_status(tag, 1'b1, 1'b0, CW'(i));
      tick();
    end
    chk_status({tag, "_end"}, 1'b0, 1'b1, '0);
  endtask

  initial begin
    RST = 1'b0; EN = 1'b1; MODE = 2'b11; START = 1'b1; D = 8'hFF;
    SI_MSB = 1'b0; SI_LSB = 1'b0;
    #1;
    tick();
    tick();
    chk("rst_q", 32'(Q), 32'h00);
    chk_status("rst", 1'b0, 1'b0, '0);

    // Manual modes
    RST = 1'b1; START = 1'b0; D = 8'hA5; MODE = 2'b11; EN = 1'b1;
    tick();
    chk("load_q", 32'(Q), 32'hA5);
    MODE = 2'b01; SI_MSB = 1'b1;
    tick();
    chk("shr_q", 32'(Q), 32'hD2);
    MODE = 2'b10; SI_LSB = 1'b0;
    tick();
    chk("shl_q", 32'(Q), 32'hA4);
    EN = 1'b0; MODE = 2'b01;
    tick();
    chk("hold_q", 32'(Q), 32'hA4);
    chk("hold_so_lsb", 32'(SO_LSB), 32'h0);
    chk("hold_so_msb", 32'(SO_MSB), 32'h1);
    chk_status("idle", 1'b0, 1'b0, '0);

    // Clean serialize of 0xB3
    SI_MSB = 1'b0; MODE = 2'b00; D = 8'hB3; START = 1'b1;
    tick();
    START = 1'b0;
    chk_serial("ser", 8'hB3);
    chk("ser_final_q", 32'(Q), 32'h00);
    tick();
    chk_status("ser_idle", 1'b0, 1'b0, '0);

    // Serialize with junk on ignored inputs; START stays high to re-trigger
    D = 8'hB3; START = 1'b1;
    tick();
    EN = 1'b1; MODE = 2'b11; D = 8'hFF;
    chk_serial("ign", 8'hB3);
    chk("ign_done_q", 32'(Q), 32'h00);
    tick();
    chk("ign_idle_q", 32'(Q), 32'h00);
    chk_status("ign_idle", 1'b0, 1'b0, '0);
    tick();
    chk("retrig_q", 32'(Q), 32'hFF);
    START = 1'b0;
    chk_serial("retrig", 8'hFF);
    tick();
    chk_status("retrig_idle", 1'b0, 1'b0, '0);

    // Reset in the middle of a serialization
    EN = 1'b0; MODE = 2'b00; D = 8'h5A; START = 1'b1;
    tick();
    START = 1'b0;
    chk("mid_q0", 32'(Q), 32'h5A);
    tick(); tick(); tick();
    chk_status("mid_cnt3", 1'b1, 1'b0, CW'(3));
    chk("mid_so3", 32'(SO_LSB), 32'h1);
    RST = 1'b0;
    tick();
    chk("mid_rst_q", 32'(Q), 32'h00);
    chk_status("mid_rst", 1'b0, 1'b0, '0);
    RST = 1'b1;
    tick();
    chk_status("mid_after", 1'b0, 1'b0, '0);

    // START beats EN/MODE in IDLE
    START = 1'b1; EN = 1'b1; MODE = 2'b01; D = 8'hC3; SI_MSB = 1'b1;
    tick();
    START = 1'b0;
    chk("prio_q", 32'(Q), 32'hC3);
    chk_serial("prio", 8'hC3);
    chk("prio_final_q", 32'(Q), 32'hFF);
    tick();
    chk_status("prio_idle", 1'b0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
